spi_rx_burst_ctrl: RTL and testbench

- Downstream controller for the serial byte reader; sequences multi-byte SPI reads.
- Pulses the reader's start input once per byte and captures each byte on the reader's done pulse.
- Buffers captured bytes in a small FIFO and presents them on a valid/ready stream with a last-byte flag.
- Throttles the reader under backpressure and times out if the reader stalls.

---
 rtl/spi_pkg.sv | 22 ++
 rtl/spi_rx_burst_ctrl_if.sv | 28 ++
 rtl/spi_rx_fifo.sv | 58 +++++
 rtl/spi_rx_burst_ctrl.sv | 123 ++++++++++++
 tb/tb_spi_rx_burst_ctrl.sv | 329 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/spi_pkg.sv
// Shared definitions for the SPI burst receive controller: state encoding,
// width helpers and default timing.
package spi_pkg;

    localparam int BYTE_W      = 8;
    localparam int TMO_W       = 8;
    localparam int DEF_TIMEOUT = 255;

    typedef enum logic [4:0] {
        ST_IDLE   = 5'b00001,
        ST_ISSUE  = 5'b00010,
        ST_WAIT   = 5'b00100,
        ST_GAP    = 5'b01000,
        ST_FINISH = 5'b10000
    } state_e;

    // Length fields must hold MAX_LEN itself, hence one bit above clog2.
    function automatic int len_width(input int max_len);
        return $clog2(max_len) + 1;
    endfunction

endpackage

// File: rtl/spi_rx_burst_ctrl_if.sv
// Request, byte-reader and receive-stream signals of the burst controller.
// The slave modport is the controller's view; master is the surrounding system.
interface spi_rx_burst_ctrl_if #(
    parameter int LEN_W = 5
);
    logic             req;
    logic [LEN_W-1:0] req_len;
    logic             busy;
    logic             rd_start;
    logic             rd_done;
    logic [7:0]       rd_data;
    logic [7:0]       rx_data;
    logic             rx_valid;
    logic             rx_ready;
    logic             rx_last;
    logic             err;
    logic [LEN_W-1:0] bytes_left;

    modport slave (
        input  req, req_len, rd_done, rd_data, rx_ready,
        output busy, rd_start, rx_data, rx_valid, rx_last, err, bytes_left
    );

    modport master (
        output req, req_len, rd_done, rd_data, rx_ready,
        input  busy, rd_start, rx_data, rx_valid, rx_last, err, bytes_left
    );
endinterface

// File: rtl/spi_rx_fifo.sv
// Synchronous capture FIFO; no fall-through, so a write into an empty FIFO
// becomes visible on the following cycle.
module spi_rx_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 9,
    localparam int AW   = $clog2(DEPTH),
    localparam int CW   = AW + 1
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_wr_en,
    input  logic [WIDTH-1:0] i_wr_data,
    input  logic             i_rd_en,
    output logic [WIDTH-1:0] o_rd_data,
    output logic             o_full,
    output logic             o_empty,
    output logic [CW-1:0]    o_count
);
    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_count;
    logic             w_do_wr;
    logic             w_do_rd;

    assign o_full  = (r_count == CW'(DEPTH));
    assign o_empty = (r_count == '0);
    assign o_count = r_count;

    // A read in the same cycle frees the slot a full-FIFO write lands in.
    assign w_do_rd = i_rd_en && !o_empty;
    assign w_do_wr = i_wr_en && (!o_full || w_do_rd);

    assign o_rd_data = r_mem[r_rd_ptr];

    always_ff @(posedge i_clk) begin
        if (w_do_wr) begin
            r_mem[r_wr_ptr] <= i_wr_data;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_wr) r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_do_rd) r_rd_ptr <= r_rd_ptr + AW'(1);
            case ({w_do_wr, w_do_rd})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/spi_rx_burst_ctrl.sv
// Sequences multi-byte reads from the serial byte reader, buffers captured
// bytes and streams them out with a last-of-burst tag.
module spi_rx_burst_ctrl
    import spi_pkg::*;
#(
    parameter int MAX_LEN    = 16,
    parameter int FIFO_DEPTH = 8,
    parameter int TIMEOUT    = DEF_TIMEOUT,
    localparam int LEN_W     = len_width(MAX_LEN),
    localparam int CNT_W     = $clog2(FIFO_DEPTH) + 1,
    localparam int ENT_W     = BYTE_W + 1
) (
    input  logic                i_clk,
    input  logic                i_rst,
    spi_rx_burst_ctrl_if.slave  bus
);
    state_e             r_state;
    state_e             w_next;
    logic [LEN_W-1:0]   r_bytes_left;
    logic [TMO_W-1:0]   r_tmo;
    logic               r_err;

    logic               w_len_ok;
    logic               w_accept;
    logic               w_start;
    logic               w_tmo_hit;
    logic               w_rd_en;
    logic               w_wr_en;
    logic               w_slot_free;
    logic               w_full;
    logic               w_empty;
    logic [CNT_W-1:0]   w_count;
    logic [ENT_W-1:0]   w_head;
    logic [ENT_W-1:0]   w_wr_entry;

    assign w_len_ok   = (bus.req_len != '0) && (bus.req_len <= LEN_W'(MAX_LEN));
    assign w_accept   = (r_state == ST_IDLE) && bus.req && w_len_ok;
    assign w_rd_en    = !w_empty && bus.rx_ready;
    assign w_slot_free = (w_count < CNT_W'(FIFO_DEPTH)) || w_rd_en;
    assign w_tmo_hit  = (r_tmo == '0);
    assign w_wr_en    = (r_state == ST_WAIT) && bus.rd_done && (!w_full || w_rd_en);
    assign w_wr_entry = {(r_bytes_left == LEN_W'(1)), bus.rd_data};

    always_comb begin
        w_next  = r_state;
        w_start = 1'b0;
        unique case (r_state)
            ST_IDLE: begin
                if (w_accept) w_next = ST_ISSUE;
            end
            ST_ISSUE: begin
                if (w_slot_free) begin
                    w_start = 1'b1;
                    w_next  = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (bus.rd_done)    w_next = ST_GAP;
                else if (w_tmo_hit) w_next = ST_FINISH;
            end
            ST_GAP: begin
                w_next = (r_bytes_left != '0) ? ST_ISSUE : ST_FINISH;
            end
            ST_FINISH: begin
                w_next = ST_IDLE;
            end
            default: begin
                w_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state      <= ST_IDLE;
            r_bytes_left <= '0;
            r_tmo        <= '0;
            r_err        <= 1'b0;
        end else begin
            r_state <= w_next;

            if (w_accept)     r_bytes_left <= bus.req_len;
            else if (w_wr_en) r_bytes_left <= r_bytes_left - LEN_W'(1);

            // Down-counter reaches zero exactly TIMEOUT cycles after the start pulse.
            if (w_start)
                r_tmo <= TMO_W'(TIMEOUT - 1);
            else if (r_state == ST_WAIT && !w_tmo_hit)
                r_tmo <= r_tmo - TMO_W'(1);

            if (w_accept)
                r_err <= 1'b0;
            else if (r_state == ST_IDLE && bus.req && !w_len_ok)
                r_err <= 1'b1;
            else if (r_state == ST_WAIT && !bus.rd_done && w_tmo_hit)
                r_err <= 1'b1;
        end
    end

    spi_rx_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (ENT_W)
    ) u_fifo (
        .i_clk     (i_clk),
        .i_rst     (i_rst),
        .i_wr_en   (w_wr_en),
        .i_wr_data (w_wr_entry),
        .i_rd_en   (w_rd_en),
        .o_rd_data (w_head),
        .o_full    (w_full),
        .o_empty   (w_empty),
        .o_count   (w_count)
    );

    assign bus.rd_start   = w_start;
    assign bus.busy       = (r_state != ST_IDLE);
    assign bus.bytes_left = r_bytes_left;
    assign bus.err        = r_err;
    assign bus.rx_valid   = !w_empty;
    assign bus.rx_data    = w_empty ? '0 : w_head[BYTE_W-1:0];
    assign bus.rx_last    = w_empty ? 1'b0 : w_head[BYTE_W];

endmodule

// File: tb/tb_spi_rx_burst_ctrl.sv
// Scoreboard bench for spi_rx_burst_ctrl: a reader model answers start pulses,
// queues the expected stream, and a monitor checks every delivered byte.
module tb_spi_rx_burst_ctrl;
    import spi_pkg::*;

    localparam int MAX_LEN = 16;
    localparam int DEPTH   = 8;
    localparam int TMO     = 255;
    localparam int LW      = len_width(MAX_LEN);

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    spi_rx_burst_ctrl_if #(.LEN_W(LW)) bus();

    spi_rx_burst_ctrl #(
        .MAX_LEN    (MAX_LEN),
        .FIFO_DEPTH (DEPTH),
        .TIMEOUT    (TMO)
    ) dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus)
    );

    int n_chk  = 0;
    int n_fail = 0;
    int cyc    = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Reference model state
    logic [8:0] exp_q [$];
    logic [7:0] data_q [$];
    int cur_len    = 0;
    int served     = 0;
    int lat_cfg    = 1;
    int stall_nth  = 0;
    int dbl        = 0;
    int rst_gen    = 0;
    int spur_cnt   = 0;
    int ready_mode = 1;
    int n_start    = 0;
    int last_start_cyc = 0;

    task automatic check(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, required 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Byte reader model: one byte per start pulse after a programmable latency.
    initial begin : reader
        int lat;
        int g;
        int spur_done;
        logic [7:0] d;
        spur_done   = 0;
        bus.rd_done = 1'b0;
        bus.rd_data = 8'h00;
        forever begin
            @(negedge clk);
            if (spur_cnt != spur_done) begin
                spur_done = spur_cnt;
                @(posedge clk); #1;
                bus.rd_done = 1'b1;
                bus.rd_data = 8'h77;
                @(posedge clk); #1;
                bus.rd_done = 1'b0;
            end else if (bus.rd_start && !rst &&
                         !(stall_nth != 0 && served + 1 == stall_nth)) begin
                lat = (lat_cfg == 0) ? int'($urandom_range(1, 4)) : lat_cfg;
                g   = rst_gen;
                repeat (lat) @(posedge clk);
                #1;
                if (g == rst_gen && !rst) begin
                    if (data_q.size() != 0) d = data_q.pop_front();
                    else                    d = 8'($urandom);
                    served++;
                    exp_q.push_back({(served == cur_len), d});
                    bus.rd_done = 1'b1;
                    bus.rd_data = d;
                    @(posedge clk); #1;
                    if (dbl != 0) begin
                        bus.rd_data = ~d;
                        @(posedge clk); #1;
                    end
                    bus.rd_done = 1'b0;
                end
            end
        end
    end

    initial begin : ready_drv
        bus.rx_ready = 1'b0;
        forever begin
            @(posedge clk); #1;
            case (ready_mode)
                0:       bus.rx_ready = 1'b0;
                1:       bus.rx_ready = 1'b1;
                default: bus.rx_ready = 1'($urandom_range(0, 1));
            endcase
        end
    end

    initial begin : monitor
        logic [8:0] e;
        forever begin
            @(negedge clk);
            if (!rst && bus.rd_start) begin
                n_start++;
                last_start_cyc = cyc;
            end
            if (!rst && bus.rx_valid && bus.rx_ready) begin
                if (exp_q.size() == 0) begin
                    check("stream_unexpected_byte", exp_q.size(), 1);
                end else begin
                    e = exp_q.pop_front();
                    check("stream_rx_data", int'(bus.rx_data), int'(e[7:0]));
                    check("stream_rx_last", int'(bus.rx_last), int'(e[8]));
                end
            end
        end
    end

    task automatic send_req(input int len, input bit model);
        @(posedge clk); #1;
        if (model) begin
            cur_len = len;
            served  = 0;
        end
        bus.req     = 1'b1;
        bus.req_len = LW'(len);
        @(posedge clk); #1;
        bus.req = 1'b0;
    endtask

    task automatic wait_idle(input string name, input int budget);
        int k = 0;
        while (bus.busy && k < budget) begin
            @(negedge clk);
            k++;
        end
        check(name, int'(bus.busy), 0);
    endtask

    task automatic wait_drain(input string name, input int budget);
        int k = 0;
        while ((exp_q.size() != 0 || bus.rx_valid) && k < budget) begin
            @(negedge clk);
            k++;
        end
        check({name, "_pending"}, exp_q.size(), 0);
        check({name, "_rx_valid"}, int'(bus.rx_valid), 0);
    endtask

    task automatic set_ready(input int mode);
        ready_mode = mode;
        @(posedge clk); #2;
    endtask

    initial begin : main
        int s0;
        int k;
        int len;
        bus.req     = 1'b0;
        bus.req_len = '0;

        @(negedge clk);
        check("rst_busy",       int'(bus.busy), 0);
        check("rst_rx_valid",   int'(bus.rx_valid), 0);
        check("rst_err",        int'(bus.err), 0);
        check("rst_rd_start",   int'(bus.rd_start), 0);
        check("rst_bytes_left", int'(bus.bytes_left), 0);
        check("rst_rx_last",    int'(bus.rx_last), 0);
        check("rst_rx_data",    int'(bus.rx_data), 0);
        @(posedge clk); #1;
        rst = 1'b0;

        // Three-byte burst with fixed data
        lat_cfg = 2;
        data_q.push_back(8'hA5);
        data_q.push_back(8'h3C);
        data_q.push_back(8'hFF);
        set_ready(1);
        s0 = n_start;
        send_req(3, 1);
        check("t1_busy", int'(bus.busy), 1);
        check("t1_bytes_left", int'(bus.bytes_left), 3);
        wait_idle("t1_busy_fall", 100);
        check("t1_starts", n_start - s0, 3);
        check("t1_err", int'(bus.err), 0);
        wait_drain("t1_drain", 50);

        // Backpressure: FIFO fills, controller stalls in ISSUE
        lat_cfg = 1;
        set_ready(0);
        s0 = n_start;
        send_req(12, 1);
        repeat (80) @(negedge clk);
        check("t2_starts_stalled", n_start - s0, DEPTH);
        check("t2_busy_stalled", int'(bus.busy), 1);
        check("t2_bytes_left", int'(bus.bytes_left), 12 - DEPTH);
        check("t2_rd_start_low", int'(bus.rd_start), 0);
        set_ready(1);
        wait_idle("t2_busy_fall", 300);
        check("t2_starts_total", n_start - s0, 12);
        wait_drain("t2_drain", 50);

        // Reader stalls on byte 2: timeout
        lat_cfg   = 2;
        stall_nth = 2;
        set_ready(0);
        s0 = n_start;
        send_req(2, 1);
        k = 0;
        while (n_start - s0 < 2 && k < 50) begin
            @(negedge clk);
            k++;
        end
        check("t3_second_start", n_start - s0, 2);
        k = 0;
        while (!bus.err && k < 400) begin
            @(negedge clk);
            k++;
        end
        check("t3_err", int'(bus.err), 1);
        check("t3_tmo_latency", cyc - last_start_cyc, TMO + 1);
        wait_idle("t3_busy_fall", 10);
        check("t3_rx_valid", int'(bus.rx_valid), 1);
        check("t3_rx_last", int'(bus.rx_last), 0);
        if (exp_q.size() != 0) check("t3_head_data", int'(bus.rx_data), int'(exp_q[0][7:0]));
        stall_nth = 0;
        set_ready(1);
        wait_drain("t3_drain", 20);
        send_req(1, 1);
        check("t3_err_cleared", int'(bus.err), 0);
        check("t3_busy_next", int'(bus.busy), 1);
        wait_idle("t3_next_busy_fall", 50);
        wait_drain("t3_next_drain", 20);

        // Rejected lengths
        s0 = n_start;
        send_req(0, 0);
        check("t4_len0_err", int'(bus.err), 1);
        check("t4_len0_busy", int'(bus.busy), 0);
        send_req(1, 1);
        check("t4_valid_clears_err", int'(bus.err), 0);
        wait_idle("t4_valid_busy_fall", 50);
        wait_drain("t4_valid_drain", 20);
        s0 = n_start;
        send_req(MAX_LEN + 1, 0);
        check("t4_len17_err", int'(bus.err), 1);
        check("t4_len17_busy", int'(bus.busy), 0);
        repeat (6) @(negedge clk);
        check("t4_no_start", n_start - s0, 0);

        // Spurious RD_DONE in IDLE and GAP, REQ while busy
        spur_cnt++;
        repeat (5) @(negedge clk);
        check("t5_idle_done_ignored", int'(bus.rx_valid), 0);
        dbl     = 1;
        lat_cfg = 0;
        s0 = n_start;
        send_req(4, 1);
        repeat (4) @(negedge clk);
        send_req(9, 0);
        wait_idle("t5_busy_fall", 100);
        check("t5_starts", n_start - s0, 4);
        wait_drain("t5_drain", 30);
        dbl = 0;

        // Random bursts with random backpressure
        set_ready(2);
        for (int i = 0; i < 6; i++) begin
            len = $urandom_range(1, MAX_LEN);
            s0  = n_start;
            send_req(len, 1);
            check("rnd_bytes_left", int'(bus.bytes_left), len);
            wait_idle("rnd_busy_fall", 2000);
            check("rnd_starts", n_start - s0, len);
            wait_drain("rnd_drain", 500);
        end

        // Reset in the middle of a burst
        lat_cfg = 1;
        set_ready(0);
        send_req(5, 1);
        k = 0;
        while (served < 3 && k < 60) begin
            @(negedge clk);
            k++;
        end
        @(posedge clk); #1;
        check("t6_queued_valid", int'(bus.rx_valid), 1);
        #2;
        rst = 1'b1;
        rst_gen++;
        #1;
        check("t6_rst_rx_valid", int'(bus.rx_valid), 0);
        check("t6_rst_busy", int'(bus.busy), 0);
        check("t6_rst_bytes_left", int'(bus.bytes_left), 0);
        check("t6_rst_rd_start", int'(bus.rd_start), 0);
        exp_q.delete();
        served = 0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        set_ready(1);
        s0 = n_start;
        send_req(1, 1);
        wait_idle("t6_fresh_busy_fall", 50);
        check("t6_fresh_starts", n_start - s0, 1);
        check("t6_fresh_err", int'(bus.err), 0);
        wait_drain("t6_fresh_drain", 20);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation time limit reached, %0d checks, %0d failures", n_chk, n_fail);
        $fatal(1, "watchdog expired");
    end

endmodule
